// File: rtl/per2axi_req_channel.sv
// Request-side converter of the per2axi bridge: turns single-beat peripheral requests into
// single-beat AXI AW+W (write) or AR (read) requests and tracks outstanding transactions.
module per2axi_req_channel #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // peripheral slave side
  input  logic                                   per_req_i,
  input  logic [ADDR_WIDTH-1:0]                  per_add_i,
  input  logic                                   per_we_n_i,
  input  logic [DATA_WIDTH-1:0]                  per_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]                per_be_i,
  input  logic [ID_WIDTH-1:0]                    per_id_i,
  output logic                                   per_gnt_o,
  // AW channel
  output logic                                   aw_valid_o,
  output logic [ADDR_WIDTH-1:0]                  aw_addr_o,
  output logic [ID_WIDTH-1:0]                    aw_id_o,
  input  logic                                   aw_ready_i,
  // W channel
  output logic                                   w_valid_o,
  output logic [DATA_WIDTH-1:0]                  w_data_o,
  output logic [DATA_WIDTH/8-1:0]                w_strb_o,
  output logic                                   w_last_o,
  input  logic                                   w_ready_i,
  // AR channel
  output logic                                   ar_valid_o,
  output logic [ADDR_WIDTH-1:0]                  ar_addr_o,
  output logic [ID_WIDTH-1:0]                    ar_id_o,
  input  logic                                   ar_ready_i,
  // response channel interface
  output logic                                   trans_valid_o,
  output logic                                   trans_we_o,
  output logic [ID_WIDTH-1:0]                    trans_id_o,
  input  logic                                   rsp_done_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic                  ar_pend_q, ar_pend_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [ID_WIDTH-1:0]   aw_id_q, ar_id_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [StrbW-1:0]      w_strb_q;
  logic                  trans_valid_q, trans_we_q;
  logic [ID_WIDTH-1:0]   trans_id_q;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic free, gnt, wr_gnt, rd_gnt, dec;

  // A slot is free when nothing is pending or everything pending handshakes this cycle.
  always_comb begin
    free   = (~aw_pend_q | aw_ready_i) & (~w_pend_q | w_ready_i) & (~ar_pend_q | ar_ready_i);
    gnt    = per_req_i & free & (cnt_q < CntW'(MAX_OUTSTANDING)) & ~rst_i;
    wr_gnt = gnt & ~per_we_n_i;
    rd_gnt = gnt & per_we_n_i;
  end

  // A new grant wins over a same-cycle handshake clear.
  always_comb begin
    aw_pend_d = (aw_pend_q & ~aw_ready_i) | wr_gnt;
    w_pend_d  = (w_pend_q & ~w_ready_i) | wr_gnt;
    ar_pend_d = (ar_pend_q & ~ar_ready_i) | rd_gnt;
  end

  // Done at zero is dropped so the counter cannot underflow.
  always_comb begin
    dec   = rsp_done_i & (cnt_q != '0);
    cnt_d = cnt_q;
    case ({gnt, dec})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      ar_pend_q     <= 1'b0;
      trans_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      ar_pend_q     <= ar_pend_d;
      trans_valid_q <= gnt;
      cnt_q         <= cnt_d;
    end
  end

  // Payload registers load only on a grant, so they stay stable while valid is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      trans_we_q <= 1'b0;
      trans_id_q <= '0;
    end else begin
      if (wr_gnt) begin
        aw_addr_q <= per_add_i;
        aw_id_q   <= per_id_i;
        w_data_q  <= per_wdata_i;
        w_strb_q  <= per_be_i;
      end
      if (rd_gnt) begin
        ar_addr_q <= per_add_i;
        ar_id_q   <= per_id_i;
      end
      if (gnt) begin
        trans_we_q <= ~per_we_n_i;
        trans_id_q <= per_id_i;
      end
    end
  end

  always_comb begin
    per_gnt_o     = gnt;
    aw_valid_o    = aw_pend_q;
    aw_addr_o     = aw_addr_q;
    aw_id_o       = aw_id_q;
    w_valid_o     = w_pend_q;
    w_data_o      = w_data_q;
    w_strb_o      = w_strb_q;
    w_last_o      = 1'b1;
    ar_valid_o    = ar_pend_q;
    ar_addr_o     = ar_addr_q;
    ar_id_o       = ar_id_q;
    trans_valid_o = trans_valid_q;
    trans_we_o    = trans_we_q;
    trans_id_o    = trans_id_q;
    outstanding_o = cnt_q;
  end

endmodule

// File: tb/tb_per2axi_req_channel.sv
// Directed self-checking bench for per2axi_req_channel with hand-computed expectations.
module tb_per2axi_req_channel;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        per_req_i;
  logic [31:0] per_add_i;
  logic        per_we_n_i;
  logic [31:0] per_wdata_i;
  logic [3:0]  per_be_i;
  logic [3:0]  per_id_i;
  logic        per_gnt_o;
  logic        aw_valid_o;
  logic [31:0] aw_addr_o;
  logic [3:0]  aw_id_o;
  logic        aw_ready_i;
  logic        w_valid_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_strb_o;
  logic        w_last_o;
  logic        w_ready_i;
  logic        ar_valid_o;
  logic [31:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic        ar_ready_i;
  logic        trans_valid_o;
  logic        trans_we_o;
  logic [3:0]  trans_id_o;
  logic        rsp_done_i;
  logic [2:0]  outstanding_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  per2axi_req_channel #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .ID_WIDTH       (4),
    .MAX_OUTSTANDING(4)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .per_req_i    (per_req_i),
    .per_add_i    (per_add_i),
    .per_we_n_i   (per_we_n_i),
    .per_wdata_i  (per_wdata_i),
    .per_be_i     (per_be_i),
    .per_id_i     (per_id_i),
    .per_gnt_o    (per_gnt_o),
    .aw_valid_o   (aw_valid_o),
    .aw_addr_o    (aw_addr_o),
    .aw_id_o      (aw_id_o),
    .aw_ready_i   (aw_ready_i),
    .w_valid_o    (w_valid_o),
    .w_data_o     (w_data_o),
    .w_strb_o     (w_strb_o),
    .w_last_o     (w_last_o),
    .w_ready_i    (w_ready_i),
    .ar_valid_o   (ar_valid_o),
    .ar_addr_o    (ar_addr_o),
    .ar_id_o      (ar_id_o),
    .ar_ready_i   (ar_ready_i),
    .trans_valid_o(trans_valid_o),
    .trans_we_o   (trans_we_o),
    .trans_id_o   (trans_id_o),
    .rsp_done_i   (rsp_done_i),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic we_n, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] id);
    per_req_i   = req;
    per_we_n_i  = we_n;
    per_add_i   = addr;
    per_wdata_i = data;
    per_be_i    = 4'hF;
    per_id_i    = id;
  endtask

  initial begin
    rst_i      = 1'b1;
    aw_ready_i = 1'b0;
    w_ready_i  = 1'b0;
    ar_ready_i = 1'b0;
    rsp_done_i = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    check("rst_gnt", 32'(per_gnt_o), 32'd0);
    rst_i = 1'b0;
    check("rst_valids", 32'({aw_valid_o, w_valid_o, ar_valid_o, trans_valid_o}), 32'd0);
    check("rst_cnt", 32'(outstanding_o), 32'd0);
    check("rst_addr", aw_addr_o | ar_addr_o | w_data_o, 32'd0);
    check("w_last", 32'(w_last_o), 32'd1);

    // Single read
    ar_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h1000_0040, 32'h0, 4'd3);
    #1 check("rd_gnt", 32'(per_gnt_o), 32'd1);
    tick();
    per_req_i = 1'b0;
    check("rd_arvalid", 32'(ar_valid_o), 32'd1);
    check("rd_araddr", ar_addr_o, 32'h1000_0040);
    check("rd_arid", 32'(ar_id_o), 32'd3);
    check("rd_trans", 32'({trans_valid_o, trans_we_o}), 32'b10);
    check("rd_cnt", 32'(outstanding_o), 32'd1);
    tick();
    check("rd_arvalid_drop", 32'(ar_valid_o), 32'd0);
    check("rd_trans_drop", 32'(trans_valid_o), 32'd0);
    rsp_done_i = 1'b1;
    tick();
    rsp_done_i = 1'b0;
    check("rd_cnt_drain", 32'(outstanding_o), 32'd0);

    // Write with AW ready in cycle 1, W ready only in cycle 4
    ar_ready_i = 1'b0;
    drive(1'b0, 1'b0, 32'h2000_0000, 32'hDEAD_BEEF, 4'd5);
    per_req_i = 1'b1;
    #1 check("wr_gnt", 32'(per_gnt_o), 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'h3000_0000, 32'h0, 4'd6);
    aw_ready_i = 1'b1;
    #1;
    check("wr_c1_valids", 32'({aw_valid_o, w_valid_o}), 32'b11);
    check("wr_c1_trans", 32'({trans_valid_o, trans_we_o, trans_id_o}), 32'b11_0101);
    check("wr_awaddr", aw_addr_o, 32'h2000_0000);
    check("wr_strb", 32'(w_strb_o), 32'hF);
    check("wr_c1_gnt", 32'(per_gnt_o), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      aw_ready_i = 1'b0;
      w_ready_i  = (c == 4);
      #1;
      check($sformatf("wr_c%0d_awvalid", c), 32'(aw_valid_o), 32'd0);
      check($sformatf("wr_c%0d_wvalid", c), 32'(w_valid_o), 32'd1);
      check($sformatf("wr_c%0d_wdata", c), w_data_o, 32'hDEAD_BEEF);
      check($sformatf("wr_c%0d_gnt", c), 32'(per_gnt_o), (c == 4) ? 32'd1 : 32'd0);
    end
    tick();
    per_req_i  = 1'b0;
    w_ready_i  = 1'b0;
    ar_ready_i = 1'b1;
    rsp_done_i = 1'b1;
    check("wr_c5_wvalid", 32'(w_valid_o), 32'd0);
    check("wr_c5_ar", {ar_valid_o, ar_addr_o[30:0]}, {1'b1, 31'h3000_0000});
    check("wr_c5_trans", 32'({trans_valid_o, trans_we_o, trans_id_o}), 32'b10_0110);
    check("wr_c5_cnt", 32'(outstanding_o), 32'd2);
    tick();
    tick();
    rsp_done_i = 1'b0;
    check("wr_cnt_drain", 32'(outstanding_o), 32'd0);

    // Back-to-back reads until the outstanding limit
    for (int k = 0; k <= 4; k++) begin
      drive(1'b1, 1'b1, 32'h4000_0000 + 32'(4 * k), 32'h0, 4'(k));
      #1;
      if (k > 0) begin
        check($sformatf("b2b_%0d_arvalid", k), 32'(ar_valid_o), 32'd1);
        check($sformatf("b2b_%0d_araddr", k), ar_addr_o, 32'h4000_0000 + 32'(4 * (k - 1)));
      end
      check($sformatf("b2b_%0d_gnt", k), 32'(per_gnt_o), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) tick();
    end
    check("b2b_cnt_full", 32'(outstanding_o), 32'd4);
    per_req_i = 1'b0;

    // Counter corners: done+grant at 2, done at 0
    rsp_done_i = 1'b1;
    tick();
    tick();
    check("cnt_two", 32'(outstanding_o), 32'd2);
    drive(1'b1, 1'b1, 32'h5000_0000, 32'h0, 4'd9);
    #1 check("cnt_sim_gnt", 32'(per_gnt_o), 32'd1);
    tick();
    per_req_i = 1'b0;
    check("cnt_sim_hold", 32'(outstanding_o), 32'd2);
    tick();
    tick();
    check("cnt_zero", 32'(outstanding_o), 32'd0);
    tick();
    rsp_done_i = 1'b0;
    check("cnt_no_underflow", 32'(outstanding_o), 32'd0);

    // Asynchronous reset while a write is pending
    aw_ready_i = 1'b0;
    w_ready_i  = 1'b0;
    drive(1'b1, 1'b0, 32'h6000_0000, 32'h1234_5678, 4'd2);
    #1 check("arst_gnt", 32'(per_gnt_o), 32'd1);
    tick();
    per_req_i = 1'b0;
    check("arst_pre", 32'({w_valid_o, outstanding_o}), 32'b1_001);
    #1 rst_i = 1'b1;
    per_req_i = 1'b1;
    #1;
    check("arst_valids", 32'({aw_valid_o, w_valid_o, ar_valid_o}), 32'd0);
    check("arst_cnt", 32'(outstanding_o), 32'd0);
    check("arst_gnt_block", 32'(per_gnt_o), 32'd0);
    #1 rst_i = 1'b0;
    aw_ready_i = 1'b1;
    w_ready_i  = 1'b1;
    drive(1'b1, 1'b0, 32'h7000_0000, 32'hCAFE_F00D, 4'd7);
    #1 check("arst_post_gnt", 32'(per_gnt_o), 32'd1);
    tick();
    per_req_i = 1'b0;
    check("arst_post_valids", 32'({aw_valid_o, w_valid_o}), 32'b11);
    check("arst_post_wdata", w_data_o, 32'hCAFE_F00D);
    check("arst_post_trans", 32'({trans_valid_o, trans_we_o, trans_id_o}), 32'b11_0111);
    check("arst_post_cnt", 32'(outstanding_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
